dmem_port_arbiter: RTL and testbench

- Shares the single-port synchronous data memory between two requesters:
  - port C: CPU MEM stage.
  - port L: program/data loader engine (debug/boot loader).
- CPU has priority. A starvation counter guarantees loader progress.
- Loader may lock the memory for a multi-beat burst. The CPU MEM stage is stalled via cpu_stall while it is denied.
- Sits between the pipeline's MEM stage, the loader and the data memory macro.

---
 rtl/dmem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: CPU MEM stage vs loader engine, CPU-priority with
// loader starvation guard, lockable loader bursts and one-cycle read return tags.
module dmem_port_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned LOCK_MAX     = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic              ldr_lock,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_gnt,
    output logic              ldr_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              lock_timeout,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned STARVE_W = 4;
    localparam int unsigned LOCK_W   = 8;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [STARVE_W-1:0] starve_cnt;
    logic [STARVE_W-1:0] starve_nxt;
    logic [LOCK_W-1:0]   lock_cnt;
    logic [LOCK_W-1:0]   lock_nxt;
    logic                timeout_nxt;
    logic                force_l;
    logic                cpu_tag;
    logic                ldr_tag;

    // Grant decision, burst tracking and starvation accounting
    always_comb begin
        state_nxt   = state;
        starve_nxt  = starve_cnt;
        lock_nxt    = lock_cnt;
        timeout_nxt = lock_timeout;
        force_l     = 1'b0;
        cpu_gnt     = 1'b0;
        ldr_gnt     = 1'b0;
        if (!reset) begin
            unique case (state)
                ARB: begin
                    force_l = (starve_cnt == STARVE_W'(STARVE_LIMIT));
                    ldr_gnt = ldr_req && (!cpu_req || force_l);
                    cpu_gnt = cpu_req && !ldr_gnt;
                    if (ldr_gnt && ldr_lock) begin
                        state_nxt = LOCKED;
                        lock_nxt  = LOCK_W'(1);
                    end
                end
                LOCKED: begin
                    ldr_gnt = ldr_req;
                    if (ldr_gnt) begin
                        // Beat LOCK_MAX of a burst always releases the lock
                        if (lock_cnt == LOCK_W'(LOCK_MAX - 1)) begin
                            state_nxt = ARB;
                            lock_nxt  = '0;
                            if (ldr_lock) begin
                                timeout_nxt = 1'b1;
                            end
                        end else if (ldr_lock) begin
                            lock_nxt = lock_cnt + LOCK_W'(1);
                        end else begin
                            state_nxt = ARB;
                            lock_nxt  = '0;
                        end
                    end
                end
                default: state_nxt = ARB;
            endcase
            if (ldr_req && !ldr_gnt) begin
                starve_nxt = (starve_cnt == STARVE_W'(STARVE_LIMIT)) ? starve_cnt
                                                                     : starve_cnt + STARVE_W'(1);
            end else begin
                starve_nxt = '0;
            end
        end
    end

    // Memory request mux; idle bus is driven to zero
    always_comb begin
        mem_en    = cpu_gnt | ldr_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (ldr_gnt) begin
            mem_we    = ldr_we;
            mem_addr  = ldr_addr;
            mem_wdata = ldr_wdata;
        end
    end

    assign cpu_stall  = !reset && cpu_req && !cpu_gnt;
    assign cpu_rvalid = !reset && cpu_tag;
    assign ldr_rvalid = !reset && ldr_tag;
    assign rdata      = mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ARB;
            starve_cnt   <= '0;
            lock_cnt     <= '0;
            lock_timeout <= 1'b0;
            cpu_tag      <= 1'b0;
            ldr_tag      <= 1'b0;
        end else begin
            state        <= state_nxt;
            starve_cnt   <= starve_nxt;
            lock_cnt     <= lock_nxt;
            lock_timeout <= timeout_nxt;
            cpu_tag      <= cpu_gnt && !cpu_we;
            ldr_tag      <= ldr_gnt && !ldr_we;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized scoreboard bench for dmem_port_arbiter with a behavioural
// arbitration/memory model and a decoupled read-return monitor.
module tb_dmem_port_arbiter;

    localparam int unsigned AW     = 32;
    localparam int unsigned DW     = 32;
    localparam int unsigned SLIMIT = 4;
    localparam int unsigned LMAX   = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt, cpu_stall, cpu_rvalid;
    logic          ldr_req, ldr_we, ldr_lock;
    logic [AW-1:0] ldr_addr;
    logic [DW-1:0] ldr_wdata;
    logic          ldr_gnt, ldr_rvalid;
    logic [DW-1:0] rdata;
    logic          lock_timeout;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    dmem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SLIMIT), .LOCK_MAX(LMAX)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_lock(ldr_lock), .ldr_addr(ldr_addr),
        .ldr_wdata(ldr_wdata), .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid),
        .rdata(rdata), .lock_timeout(lock_timeout),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc++;

    // Synchronous single-port memory macro (16 words)
    logic [DW-1:0] mem [16];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[5:2]];
        end
    end

    typedef struct {
        bit          is_ldr;
        logic [31:0] data;
        int          issue;
    } rd_exp_t;

    rd_exp_t exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model state
    bit            m_locked;
    int            m_beats;
    int            m_denied;
    bit            m_timeout;
    logic [31:0]   m_mem [16];

    // Grant/bus checker and expectation producer
    always @(negedge clk) begin
        bit          eg_c, eg_l, e_we;
        logic [31:0] e_addr, e_wdata;
        rd_exp_t     e;
        if (reset) begin
            chk("rst_cpu_gnt", 32'(cpu_gnt), 0);
            chk("rst_ldr_gnt", 32'(ldr_gnt), 0);
            chk("rst_cpu_stall", 32'(cpu_stall), 0);
            chk("rst_mem_en", 32'(mem_en), 0);
            chk("rst_mem_we", 32'(mem_we), 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            m_locked  = 0;
            m_beats   = 0;
            m_denied  = 0;
            m_timeout = 0;
        end else begin
            if (m_locked) begin
                eg_l = ldr_req;
                eg_c = 1'b0;
            end else begin
                eg_l = ldr_req && (!cpu_req || m_denied >= int'(SLIMIT));
                eg_c = cpu_req && !eg_l;
            end
            e_we    = eg_c ? cpu_we : (eg_l ? ldr_we : 1'b0);
            e_addr  = eg_c ? cpu_addr : (eg_l ? ldr_addr : 32'h0);
            e_wdata = eg_c ? cpu_wdata : (eg_l ? ldr_wdata : 32'h0);
            chk("cpu_gnt", 32'(cpu_gnt), 32'(eg_c));
            chk("ldr_gnt", 32'(ldr_gnt), 32'(eg_l));
            chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !eg_c));
            chk("mem_en", 32'(mem_en), 32'(eg_c || eg_l));
            chk("mem_we", 32'(mem_we), 32'(e_we));
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wdata", mem_wdata, e_wdata);
            chk("lock_timeout", 32'(lock_timeout), 32'(m_timeout));
            if (eg_c || eg_l) begin
                if (e_we) begin
                    m_mem[e_addr[5:2]] = e_wdata;
                end else begin
                    e.is_ldr = eg_l;
                    e.data   = m_mem[e_addr[5:2]];
                    e.issue  = cyc;
                    exp_q.push_back(e);
                end
            end
            m_denied = (ldr_req && !eg_l) ? m_denied + 1 : 0;
            if (eg_l) begin
                if (!m_locked) begin
                    if (ldr_lock) begin
                        m_locked = 1;
                        m_beats  = 1;
                    end
                end else begin
                    m_beats++;
                    if (m_beats == int'(LMAX)) begin
                        m_locked = 0;
                        if (ldr_lock) m_timeout = 1;
                    end else if (!ldr_lock) begin
                        m_locked = 0;
                    end
                end
            end
        end
    end

    // Read-return monitor
    always @(negedge clk) begin
        rd_exp_t e;
        if (reset) begin
            chk("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
            chk("rst_ldr_rvalid", 32'(ldr_rvalid), 0);
            exp_q.delete();
        end else if (cpu_rvalid || ldr_rvalid) begin
            if (cpu_rvalid && ldr_rvalid) chk("rvalid_both", 32'(1), 0);
            if (exp_q.size() == 0) begin
                chk("rvalid_unexpected", 32'(1), 0);
            end else begin
                e = exp_q.pop_front();
                chk("rvalid_port_ldr", 32'(ldr_rvalid), 32'(e.is_ldr));
                chk("rvalid_latency", cyc - e.issue, 1);
                chk("rdata", rdata, e.data);
            end
        end else if (exp_q.size() > 0 && exp_q[0].issue < cyc) begin
            e = exp_q.pop_front();
            chk("rvalid_missing", 0, 32'(1));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        ldr_req = 0; ldr_we = 0; ldr_lock = 0; ldr_addr = '0; ldr_wdata = '0;
    endtask

    // Present one loader beat and hold it until it is granted
    task automatic ldr_beat(input logic we, input logic lock, input logic [31:0] addr,
                            input logic [31:0] wdata);
        bit got;
        ldr_req = 1; ldr_we = we; ldr_lock = lock; ldr_addr = addr; ldr_wdata = wdata;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = ldr_gnt;
            step();
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL ldr_beat_wait: no grant for addr %h within 20 cycles", addr);
        end
    endtask

    initial begin
        idle();
        reset = 1;
        step();
        step();
        reset = 0;

        // Fill memory through the CPU port
        for (int i = 0; i < 16; i++) begin
            cpu_req = 1; cpu_we = 1; cpu_addr = 32'(i * 4);
            cpu_wdata = (i == 4) ? 32'hDEADBEEF : $urandom;
            step();
        end
        idle();

        // CPU-only read of 0x10
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        step();
        idle();
        step();

        // Both ports requesting continuously
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h4;
        ldr_req = 1; ldr_we = 0; ldr_addr = 32'h8;
        for (int i = 0; i < 15; i++) step();
        idle();
        step();

        // Short locked write burst against a busy CPU
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'hC;
        ldr_beat(1, 1, 32'h100, 32'h1111_0000);
        ldr_beat(1, 1, 32'h104, 32'h2222_0000);
        ldr_beat(1, 0, 32'h108, 32'h3333_0000);
        ldr_req = 0; ldr_lock = 0;
        step();
        step();

        // Lock held past LOCK_MAX beats
        for (int i = 0; i < 6; i++) ldr_beat(1, 1, 32'(32'h20 + i * 4), $urandom);
        idle();
        step();

        // Interleaved reads
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        step();
        idle();
        ldr_req = 1; ldr_we = 0; ldr_addr = 32'h24;
        step();
        idle();
        step();

        // Reset right after a granted read inside a locked burst
        ldr_beat(0, 1, 32'h4, 32'h0);
        ldr_beat(0, 1, 32'h8, 32'h0);
        idle();
        reset = 1;
        step();
        reset = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h14;
        step();
        idle();
        step();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 199) == 0);
            cpu_req   = ($urandom_range(0, 9) < 7);
            cpu_we    = $urandom_range(0, 1);
            cpu_addr  = 32'($urandom_range(0, 15) * 4);
            cpu_wdata = $urandom;
            ldr_req   = $urandom_range(0, 1);
            ldr_we    = $urandom_range(0, 1);
            ldr_lock  = ($urandom_range(0, 9) < 6);
            ldr_addr  = 32'($urandom_range(0, 15) * 4);
            ldr_wdata = $urandom;
            step();
        end
        reset = 0;
        idle();
        step();
        step();
        step();
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
